obuf_frame_writer: RTL and testbench
====================================

// Module: obuf_frame_writer
// PURPOSE
// Read-side consumer of the camera output buffer FIFO. Drains 16-bit RGB565 pixels
// from the FIFO read port and writes them into a frame-buffer RAM at linear
// addresses 0..H_ACTIVE*V_ACTIVE-1. Aligns each frame to the camera start-of-frame
// flag and reports completed and short frames. Sits between the camera block's
// FIFO read port and the frame buffer, in the FIFO read clock domain.
// PARAMETERS
// H_ACTIVE    640  pixels per line
// V_ACTIVE    480  lines per frame
// ADDR_WIDTH  19   frame-buffer address width; must satisfy 2**ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
// DATA_WIDTH  16   pixel width (RGB565)
// PORTS
// i_clk          in   1           FIFO read / frame-buffer clock
// i_rst          in   1           asynchronous reset, active-high
// i_enable       in   1           capture enable; sampled only at frame boundaries
// i_sof          in   1           camera-domain start-of-frame pulse (>=1 pclk wide)
// o_obuf_rd      out  1           FIFO read enable
// i_obuf_data    in   DATA_WIDTH  FIFO read data; valid 1 cycle after o_obuf_rd
// i_obuf_empty   in   1           FIFO empty flag
// o_fb_we        out  1           frame-buffer write enable
// o_fb_addr      out  ADDR_WIDTH  frame-buffer write address
// o_fb_wdata     out  DATA_WIDTH  frame-buffer write data
// o_frame_done   out  1           1-cycle pulse: full frame written
// o_short_frame  out  1           1-cycle pulse: SOF arrived before frame complete
// o_frame_cnt    out  8           completed-frame count; wraps 255->0
// o_busy         out  1           high in FILL
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; pixel counter 0; SOF synchronizer cleared.
// - SOF: 2-flop synchronizer, then rising-edge detect -> internal sof_p (1 cycle);
//   latency 3 i_clk cycles from i_sof rise.
// - o_obuf_rd = !i_obuf_empty in every state, so the FIFO never backs up.
//   rd_q = o_obuf_rd delayed 1 cycle marks valid i_obuf_data.
// - Data on rd_q is written only in FILL; it is dropped in IDLE and DRAIN.
// - States:
//   IDLE : sof_p & i_enable -> FILL, pix_cnt=0.
//   FILL : each rd_q: o_fb_we=1, o_fb_addr=pix_cnt, o_fb_wdata=i_obuf_data
//          (registered, 1 cycle after rd_q); pix_cnt++.
//          On the write with pix_cnt==H_ACTIVE*V_ACTIVE-1: next cycle o_frame_done=1,
//          o_frame_cnt++, -> DRAIN.
//          sof_p before completion: o_short_frame=1, pix_cnt=0; i_enable ? stay FILL : IDLE.
//   DRAIN: sof_p -> i_enable ? FILL (pix_cnt=0) : IDLE.
// - sof_p and rd_q in the same FILL cycle: sof_p wins; that pixel is discarded and
//   not written. The next valid pixel goes to address 0.
// - sof_p on the same cycle as the final pixel's rd_q: the pixel is written, the frame
//   completes (o_frame_done), and the state goes directly to FILL (if i_enable) with
//   pix_cnt=0. o_short_frame stays 0.
// - i_enable deassert in FILL: no effect until the next sof_p or completion; the block
//   then goes to IDLE (via DRAIN on completion).
// - o_fb_we is never asserted outside FILL. o_fb_addr never exceeds H_ACTIVE*V_ACTIVE-1.
// - i_rst mid-frame: immediate return to IDLE; o_fb_we drops asynchronously; no pulses.
// TESTING
// (H_ACTIVE=4, V_ACTIVE=3)
// 1. i_enable=1, SOF, then 12 pixels 0x0000..0x000B fed with empty toggling ->
//    12 writes at addr 0..11 with matching data; o_frame_done 1 cycle; o_frame_cnt=1.
// 2. SOF after only 7 pixels -> o_short_frame pulse; next pixel written at addr 0;
//    o_frame_cnt unchanged.
// 3. 15 pixels in one frame -> only 12 writes; pixels 13-15 read and dropped; FIFO
//    returns to empty.
// 4. i_enable=0, SOF, then 12 pixels -> o_obuf_rd still drains the FIFO; no o_fb_we;
//    state remains IDLE.
// 5. Assert i_rst after 5 pixels -> all outputs 0 at once; after release, next SOF plus
//    12 pixels completes a clean frame starting at addr 0.
// 6. Run 256 complete frames -> o_frame_cnt wraps to 0; SOF coincident with rd_q
//    confirms the discard rule.

Source files
------------

// File: rtl/obuf_frame_writer.sv
// obuf_frame_writer: drains RGB565 pixels from the camera output FIFO into a linear
// frame buffer, aligned to the synchronized camera start-of-frame flag.
module obuf_frame_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_sof,
    output logic                  o_obuf_rd,
    input  logic [DATA_WIDTH-1:0] i_obuf_data,
    input  logic                  i_obuf_empty,
    output logic                  o_fb_we,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic [DATA_WIDTH-1:0] o_fb_wdata,
    output logic                  o_frame_done,
    output logic                  o_short_frame,
    output logic [7:0]            o_frame_cnt,
    output logic                  o_busy
);
    // state | meaning
    // IDLE  | waiting for an enabled SOF; FIFO data dropped
    // FILL  | writing pixels to addresses 0..H_ACTIVE*V_ACTIVE-1
    // DRAIN | frame complete; surplus pixels dropped until next SOF

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
    logic                    sof_s1_q, sof_s1_d;
    logic                    sof_s2_q, sof_s2_d;
    logic                    sof_s3_q, sof_s3_d;
    logic                    sof_p_q, sof_p_d;
    logic                    rd_q, rd_d;
    logic                    fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_WIDTH-1:0]   fb_wdata_q, fb_wdata_d;
    logic                    frame_done_q, frame_done_d;
    logic                    short_frame_q, short_frame_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;

    // Read whenever data is present so the camera-side FIFO never backs up.
    assign o_obuf_rd     = !i_obuf_empty && !i_rst;
    assign o_fb_we       = fb_we_q;
    assign o_fb_addr     = fb_addr_q;
    assign o_fb_wdata    = fb_wdata_q;
    assign o_frame_done  = frame_done_q;
    assign o_short_frame = short_frame_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_busy        = (state_q == ST_FILL);

    always_comb begin
        sof_s1_d      = i_sof;
        sof_s2_d      = sof_s1_q;
        sof_s3_d      = sof_s2_q;
        sof_p_d       = sof_s2_q && !sof_s3_q;
        rd_d          = o_obuf_rd;
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_wdata_d    = fb_wdata_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sof_p_q && i_enable) begin
                    state_d   = ST_FILL;
                    pix_cnt_d = '0;
                end
            end
            ST_FILL: begin
                // The final pixel is kept even if SOF lands on it; otherwise SOF wins.
                if (rd_q && (pix_cnt_q == LAST_ADDR)) begin
                    fb_we_d      = 1'b1;
                    fb_addr_d    = pix_cnt_q;
                    fb_wdata_d   = i_obuf_data;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    pix_cnt_d    = '0;
                    if (sof_p_q) begin
                        state_d = i_enable ? ST_FILL : ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (sof_p_q) begin
                    short_frame_d = 1'b1;
                    pix_cnt_d     = '0;
                    state_d       = i_enable ? ST_FILL : ST_IDLE;
                end else if (rd_q) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = pix_cnt_q;
                    fb_wdata_d = i_obuf_data;
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (sof_p_q) begin
                    state_d   = i_enable ? ST_FILL : ST_IDLE;
                    pix_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            sof_s1_q      <= 1'b0;
            sof_s2_q      <= 1'b0;
            sof_s3_q      <= 1'b0;
            sof_p_q       <= 1'b0;
            rd_q          <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            sof_s1_q      <= sof_s1_d;
            sof_s2_q      <= sof_s2_d;
            sof_s3_q      <= sof_s3_d;
            sof_p_q       <= sof_p_d;
            rd_q          <= rd_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_obuf_frame_writer.sv
// Scoreboard bench for obuf_frame_writer: a FIFO model feeds random pixels and a
// frame-level reference model predicts frame-buffer writes and frame pulses.
module tb_obuf_frame_writer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int FRAME = H * V;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic          i_sof;
    logic          o_obuf_rd;
    logic [DW-1:0] i_obuf_data;
    logic          i_obuf_empty;
    logic          o_fb_we;
    logic [AW-1:0] o_fb_addr;
    logic [DW-1:0] o_fb_wdata;
    logic          o_frame_done;
    logic          o_short_frame;
    logic [7:0]    o_frame_cnt;
    logic          o_busy;

    obuf_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_sof(i_sof),
        .o_obuf_rd(o_obuf_rd), .i_obuf_data(i_obuf_data), .i_obuf_empty(i_obuf_empty),
        .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_wdata(o_fb_wdata),
        .o_frame_done(o_frame_done), .o_short_frame(o_short_frame),
        .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int compared = 0;
    int mismatched = 0;

    // scoreboard queues
    int          exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    int          exp_done_q[$];
    int          exp_short_q[$];
    int          short_seen = 0;
    int          writes_seen = 0;

    // FIFO model and stimulus state
    logic [15:0] fifo[$];
    bit  prev_rd = 0;
    int  iter = 0;
    int  sof_at = -100;
    int  sof_hold = 0;
    int  last_raise = -100;
    bit  sof_req = 0;
    bit  en_req = 0;
    int  empty_mode = 0;

    // frame-level reference model: capturing flag and next linear address
    bit  m_cap = 0;
    int  m_pos = 0;
    int  m_frames = 0;
    int  m_completed = 0;
    int  cov_mid = 0;
    int  cov_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit sof, bit pix, logic [15:0] d, bit en);
        if (m_cap) begin
            if (sof && pix) begin
                if (m_pos == FRAME - 1) cov_last++;
                else cov_mid++;
            end
            if (pix && m_pos == FRAME - 1) begin
                exp_addr_q.push_back(m_pos);
                exp_data_q.push_back(d);
                m_frames = (m_frames + 1) % 256;
                m_completed++;
                exp_done_q.push_back(m_frames);
                m_pos = 0;
                m_cap = sof && en;
            end else if (sof) begin
                exp_short_q.push_back(1);
                m_pos = 0;
                m_cap = en;
            end else if (pix) begin
                exp_addr_q.push_back(m_pos);
                exp_data_q.push_back(d);
                m_pos++;
            end
        end else if (sof && en) begin
            m_cap = 1;
            m_pos = 0;
        end
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    int          mon_addr;
    logic [15:0] mon_data;
    int          mon_cnt;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_fb_we) begin
                writes_seen++;
                if (exp_addr_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", o_fb_addr, o_fb_wdata);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    mon_data = exp_data_q.pop_front();
                    check("wr_addr", 64'(o_fb_addr), 64'(mon_addr));
                    check("wr_data", 64'(o_fb_wdata), 64'(mon_data));
                end
            end
            if (o_frame_done) begin
                if (exp_done_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got frame_done with cnt %0d, expected none", o_frame_cnt);
                end else begin
                    mon_cnt = exp_done_q.pop_front();
                    check("frame_cnt_at_done", 64'(o_frame_cnt), 64'(mon_cnt));
                end
            end
            if (o_short_frame) begin
                short_seen++;
                if (exp_short_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_short: got short_frame pulse, expected none");
                end else begin
                    void'(exp_short_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus, applied just after the falling edge.
    task automatic cycle();
        bit          pix;
        bit          sof;
        logic [15:0] d;
        @(negedge i_clk);
        #1;
        iter++;
        check("busy", 64'(o_busy), 64'(m_cap));
        i_enable = en_req;
        pix = 0;
        d = '0;
        if (prev_rd) begin
            d = fifo.pop_front();
            i_obuf_data = d;
            pix = 1;
        end
        if (sof_hold > 0) begin
            sof_hold--;
            if (sof_hold == 0) i_sof = 1'b0;
        end
        if (sof_req) begin
            i_sof = 1'b1;
            sof_hold = 2;
            sof_at = iter + 3;
            last_raise = iter;
            sof_req = 0;
        end
        sof = (iter == sof_at);
        if (fifo.size() == 0) i_obuf_empty = 1'b1;
        else if (empty_mode == 1) i_obuf_empty = 1'b0;
        else i_obuf_empty = ($urandom_range(0, 2) == 0);
        prev_rd = !i_obuf_empty;
        model_step(sof, pix, d, i_enable);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_sof();
        int n = 0;
        while ((iter - last_raise < 8) && n < 20) begin
            cycle();
            n++;
        end
        sof_req = 1;
        cycle();
    endtask

    task automatic push_pixels(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) fifo.push_back(rnd ? 16'($urandom) : 16'(base + i));
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo.size() != 0 || prev_rd) && n < 300) begin
            cycle();
            n++;
        end
        check("fifo_drained", 64'(fifo.size()), 64'd0);
        cycles(3);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({o_obuf_rd, o_fb_we, o_fb_addr, o_fb_wdata, o_frame_done, o_short_frame, o_frame_cnt, o_busy}),
              64'd0);
        check("reset_pending_writes", 64'(exp_addr_q.size()), 64'd0);
        if (prev_rd) void'(fifo.pop_front());
        prev_rd = 0;
        i_obuf_empty = 1'b1;
        i_sof = 1'b0;
        sof_hold = 0;
        sof_req = 0;
        sof_at = -100;
        m_cap = 0;
        m_pos = 0;
        m_frames = 0;
        repeat (2) @(negedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected bench completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "time limit");
    end

    initial begin
        int w0;
        int base;
        int n;
        int f;
        i_rst = 1'b1;
        i_enable = 1'b0;
        i_sof = 1'b0;
        i_obuf_empty = 1'b1;
        i_obuf_data = '0;
        #1;
        check("reset_outputs",
              64'({o_obuf_rd, o_fb_we, o_fb_addr, o_fb_wdata, o_frame_done, o_short_frame, o_frame_cnt, o_busy}),
              64'd0);
        repeat (3) @(negedge i_clk);
        #1;
        i_rst = 1'b0;

        // 1: one full frame with a stalling FIFO
        en_req = 1;
        empty_mode = 0;
        start_sof();
        cycles(4);
        push_pixels(FRAME, 0, 0);
        drain();
        check("t1_frame_cnt", 64'(o_frame_cnt), 64'd1);

        // 2: SOF after 7 pixels, then a full frame from address 0
        start_sof();
        cycles(4);
        push_pixels(7, 0, 1);
        drain();
        start_sof();
        cycles(4);
        check("t2_cnt_after_short", 64'(o_frame_cnt), 64'd1);
        check("t2_short_seen", 64'(short_seen), 64'd1);
        push_pixels(FRAME, 16'h0100, 0);
        drain();
        check("t2_frame_cnt", 64'(o_frame_cnt), 64'd2);

        // 3: 15 pixels in one frame, surplus dropped
        start_sof();
        cycles(4);
        push_pixels(15, 16'h0200, 0);
        drain();
        check("t3_frame_cnt", 64'(o_frame_cnt), 64'd3);

        // 4: disabled capture still drains the FIFO without writing
        en_req = 0;
        w0 = writes_seen;
        start_sof();
        cycles(4);
        push_pixels(FRAME, 16'h0300, 0);
        drain();
        check("t4_no_writes", 64'(writes_seen - w0), 64'd0);
        check("t4_frame_cnt", 64'(o_frame_cnt), 64'd3);

        // 5: reset mid-frame, then a clean frame
        en_req = 1;
        start_sof();
        cycles(4);
        empty_mode = 1;
        push_pixels(8, 16'h0400, 0);
        n = 0;
        while (!(m_cap && m_pos >= 5) && n < 60) begin
            cycle();
            n++;
        end
        check("t5_reached_5_pixels", 64'(m_pos >= 5), 64'd1);
        do_reset();
        empty_mode = 0;
        cycles(2);
        start_sof();
        cycles(4);
        push_pixels(FRAME, 16'h0500, 0);
        drain();
        check("t5_frame_cnt", 64'(o_frame_cnt), 64'd1);

        // 6: random frames until the frame counter has wrapped
        base = m_completed;
        f = 0;
        while ((m_completed - base < 257) && f < 900) begin
            en_req = ($urandom_range(0, 9) != 0);
            empty_mode = $urandom_range(0, 1);
            start_sof();
            cycles($urandom_range(0, 5));
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 16) : FRAME;
            push_pixels(n, 0, 1);
            drain();
            f++;
        end
        check("t6_wrap_budget", 64'(m_completed - base >= 257), 64'd1);

        // SOF on the final pixel of a frame
        en_req = 1;
        start_sof();
        cycles(4);
        empty_mode = 1;
        push_pixels(20, 16'h0600, 0);
        n = 0;
        while (!(m_cap && m_pos == 8) && n < 40) begin
            cycle();
            n++;
        end
        sof_req = 1;
        drain();

        // SOF coincident with a mid-frame pixel
        start_sof();
        cycles(4);
        push_pixels(20, 16'h0700, 0);
        cycles(4);
        start_sof();
        drain();
        cycles(5);

        check("final_frame_cnt", 64'(o_frame_cnt), 64'(m_frames));
        check("pending_writes", 64'(exp_addr_q.size()), 64'd0);
        check("pending_done", 64'(exp_done_q.size()), 64'd0);
        check("pending_short", 64'(exp_short_q.size()), 64'd0);
        $display("coverage: mid-frame SOF/pixel collisions %0d, final-pixel collisions %0d", cov_mid, cov_last);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
